// File: rtl/map_pkg.sv
// map_pkg: definitions shared by the scrolling map generator and its consumers.
//   - 2-bit tile codes: empty, low block, high block, reserved (never generated)
//   - scroll_state_t: sequencer states of map_scroller
//   - level_thr(): obstacle probability threshold per difficulty level
//   - lfsr_next(): one step of the 16-bit right-shifting Galois LFSR
package map_pkg;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_LOW   = 2'd1;
    localparam logic [1:0] TILE_HIGH  = 2'd2;
    localparam logic [1:0] TILE_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAFE   = 3'd1,
        S_RUN    = 3'd2,
        S_GAP    = 3'd3,
        S_FROZEN = 3'd4
    } scroll_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // A draw r = lfsr[7:0] places an obstacle when r is below this value.
    function automatic logic [7:0] level_thr(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 8'd64;
            2'd1:    return 8'd96;
            2'd2:    return 8'd128;
            default: return 8'd160;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/map_lfsr.sv
// map_lfsr: 16-bit Galois LFSR that advances only when asked.
//   clk, rst_n : clock and asynchronous active-low reset
//   step       : advance one state this clock
//   seed       : reset value; an all-zero seed would lock up, so it becomes 1
//   q          : current LFSR state
module map_lfsr
    import map_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] seed_safe;
    logic [15:0] q_reg;

    assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;
    assign q         = q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= seed_safe;
        end else if (step) begin
            q_reg <= lfsr_next(q_reg);
        end
    end

endmodule

// File: rtl/map_scroller.sv
// map_scroller: scrolling obstacle map for the physics engine.
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : pulse that begins a run from IDLE or FROZEN
//   dead           : level; freezes the map while in SAFE/RUN/GAP
//   tick           : scroll strobe; each accepted tick shifts the map one tile
//   level          : difficulty 0..3, sampled on every RUN draw
//   map_tiles      : registered map, top pair is the player slot, new tiles at [1:0]
//   tile_strobe    : high for one cycle whenever map_tiles has just shifted
//   obstacle_count : saturating count of obstacles shifted out of the player slot
module map_scroller
    import map_pkg::*;
#(
    parameter int          NUM_TILES  = 8,
    parameter int          MIN_GAP    = 2,
    parameter int          SAFE_TILES = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   dead,
    input  logic                   tick,
    input  logic [1:0]             level,
    output logic [2*NUM_TILES-1:0] map_tiles,
    output logic                   tile_strobe,
    output logic [15:0]            obstacle_count
);

    localparam int MAP_W = 2 * NUM_TILES;

    scroll_state_t    state_reg;
    logic [MAP_W-1:0] map_reg;
    logic [MAP_W-1:0] map_shifted;
    logic             tile_strobe_reg;
    logic [15:0]      count_reg;
    logic [15:0]      safe_cnt_reg;
    logic [15:0]      gap_cnt_reg;

    logic [15:0]      lfsr_q;
    logic             lfsr_step;
    logic             active;
    logic             shift_en;
    logic             hit;
    logic             player_occupied;
    logic [1:0]       ins;
    logic             unused_lfsr_bits;

    assign active          = (state_reg == S_SAFE) || (state_reg == S_RUN) || (state_reg == S_GAP);
    assign shift_en        = active && !dead && tick;
    // Free-running while waiting so the first draw depends on when start arrives;
    // during a run it advances only on the ticks that actually draw.
    assign lfsr_step       = (state_reg == S_IDLE) || (state_reg == S_FROZEN) ||
                             ((state_reg == S_RUN) && shift_en);
    assign hit             = (lfsr_q[7:0] < level_thr(level));
    assign player_occupied = (map_reg[MAP_W-1:MAP_W-2] != TILE_EMPTY);
    assign unused_lfsr_bits = ^lfsr_q[15:9];

    always_comb begin
        ins = TILE_EMPTY;
        if ((state_reg == S_RUN) && hit) begin
            ins = lfsr_q[8] ? TILE_HIGH : TILE_LOW;
        end
    end

    // Shifted map: every tile moves one slot toward the player, new tile at [1:0].
    assign map_shifted[1:0] = ins;
    generate
        for (genvar gi = 1; gi < NUM_TILES; gi++) begin : g_shift
            assign map_shifted[2*gi+1:2*gi] = map_reg[2*gi-1:2*gi-2];
        end
    endgenerate

    map_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            map_reg         <= '0;
            tile_strobe_reg <= 1'b0;
            count_reg       <= 16'h0000;
            safe_cnt_reg    <= 16'h0000;
            gap_cnt_reg     <= 16'h0000;
        end else begin
            tile_strobe_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // A tick in the same cycle as start is simply dropped.
                    if (start) begin
                        state_reg    <= S_SAFE;
                        safe_cnt_reg <= 16'(SAFE_TILES);
                        count_reg    <= 16'h0000;
                    end
                end
                S_FROZEN: begin
                    if (start && !dead) begin
                        state_reg    <= S_SAFE;
                        safe_cnt_reg <= 16'(SAFE_TILES);
                        map_reg      <= '0;
                        count_reg    <= 16'h0000;
                    end
                end
                default: begin
                    if (dead) begin
                        state_reg <= S_FROZEN;
                    end else if (tick) begin
                        map_reg         <= map_shifted;
                        tile_strobe_reg <= 1'b1;
                        if (player_occupied && (count_reg != 16'hFFFF)) begin
                            count_reg <= count_reg + 16'd1;
                        end
                        case (state_reg)
                            S_SAFE: begin
                                safe_cnt_reg <= safe_cnt_reg - 16'd1;
                                if (safe_cnt_reg <= 16'd1) state_reg <= S_RUN;
                            end
                            S_GAP: begin
                                gap_cnt_reg <= gap_cnt_reg - 16'd1;
                                if (gap_cnt_reg <= 16'd1) state_reg <= S_RUN;
                            end
                            default: begin
                                // Every obstacle is followed by MIN_GAP forced empties.
                                if (hit) begin
                                    gap_cnt_reg <= 16'(MIN_GAP);
                                    state_reg   <= S_GAP;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign map_tiles      = map_reg;
    assign tile_strobe    = tile_strobe_reg;
    assign obstacle_count = count_reg;

endmodule

// File: doc/map_scroller.md
# map_scroller

Produces the scrolling obstacle map consumed by `physics_engine`. On each scroll tick it shifts the 8-tile map one slot toward the player position, which is `map_tiles[15:14]`, and inserts a new tile at `[1:0]`. New tiles come from an LFSR, gated by a difficulty level and a minimum-gap rule so every map is survivable. It also counts obstacles that scroll past the player.

## Interface
Parameters:
- `NUM_TILES`, 8: map length in tiles; each tile is 2 bits.
- `MIN_GAP`, 2: minimum empty tiles inserted after every obstacle; must be ≥1.
- `SAFE_TILES`, 8: empty tiles inserted after start before random generation begins.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse; begins a run from IDLE or FROZEN.
- `dead`, in, 1: level-sensitive player-death indication; freezes the map.
- `tick`, in, 1: one-cycle scroll strobe (the `speed` rate).
- `level`, in, 2: difficulty level, 0..3.
- `map_tiles`, out, 2*NUM_TILES: registered map; MSB pair is the player slot.
- `tile_strobe`, out, 1: one-cycle pulse in the cycle `map_tiles` holds a new value.
- `obstacle_count`, out, 16: obstacles shifted out of the player slot; saturating.

## Operation
Tile codes:
- 0 = empty
- 1 = low block
- 2 = high block
- 3 = reserved; never generated.

Shift operation:
- new map = {old[2N-3:0], ins}.
- If old[2N-1:2N-2] ≠ 0, `obstacle_count` increments, saturating at 16'hFFFF.

States: IDLE, SAFE, RUN, GAP, FROZEN.
- IDLE:
  - map is 0; LFSR steps once per clk.
  - `start` → SAFE; safe_cnt=SAFE_TILES; count cleared.
- SAFE:
  - each tick shifts in 0 and decrements safe_cnt.
  - the tick that takes safe_cnt to 0 → RUN.
- RUN, on each tick:
  - LFSR steps; r = lfsr[7:0].
  - thr = {64, 96, 128, 160} indexed by `level`.
  - If r < thr: ins = lfsr[8] ? 2 : 1; gap_cnt=MIN_GAP; → GAP.
  - Else: ins = 0; stay in RUN.
- GAP:
  - each tick shifts in 0 and decrements gap_cnt.
  - reaching 0 → RUN.
  - The LFSR does not step in GAP.
- FROZEN:
  - map and count are held; LFSR steps once per clk.
  - `start` → map cleared, count cleared, → SAFE.
- `dead`=1 in SAFE, RUN or GAP → FROZEN; no shift occurs that cycle.

LFSR:
- 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, tap mask 16'hB400.
- Shifts right; the all-zero state is unreachable.

Priorities:
- `dead` > `start` > `tick`.
- `start` in SAFE, RUN or GAP is ignored.
- `start` and `tick` in the same IDLE cycle: start is taken, the tick is dropped.
- `tick` in IDLE or FROZEN is ignored; no strobe.
- `level` is sampled on each RUN tick; mid-run changes apply to the next draw.

## Timing
- Reset values (immediate, asynchronous):
  - `map_tiles`=0, `tile_strobe`=0, `obstacle_count`=0.
  - State=IDLE, LFSR=LFSR_SEED, safe_cnt=gap_cnt=0.
- Reset mid-run aborts everything; no partial shift is visible.
- Latency: tick sampled at edge k → `map_tiles` updated and `tile_strobe`=1 after edge k (1 cycle).
- Counter updates in the same cycle as the map.
- `start` → SAFE visible the next cycle; the first SAFE shift occurs on the first tick after that.
- Back-to-back ticks on consecutive cycles are legal; each produces one shift and one strobe.
- Spacing guarantee: nonzero tiles in `map_tiles` are separated by ≥ MIN_GAP zero tiles.

## Structure
- Shared package `map_pkg`:
  - tile code constants `TILE_EMPTY`, `TILE_LOW`, `TILE_HIGH`, `TILE_RSVD`.
  - state enum `scroll_state_t`.
  - level threshold table, LFSR tap mask.
- `physics_engine` imports the same tile constants.
- One sub-module, `map_lfsr`:
  - ports: `clk`, `rst_n`, `step`, `seed`, `q[15:0]`.
  - handles zero-seed substitution.

## Test plan
- Reset, then `start` on the first cycle, then 8 ticks → `map_tiles` stays 16'h0000 and 8 strobes are seen; the 9th tick is the first RUN draw, using the LFSR state after 1 IDLE step.
- `level`=3 for 2000 ticks → no tile code 3; every strobe satisfies new[15:2]==old[13:0]; no two nonzero tiles are closer than 3 slots.
- Scoreboard over 500 ticks → `obstacle_count` equals the number of nonzero MSB pairs shifted out; a force near 16'hFFFE saturates at 16'hFFFF.
- `dead` and `tick` asserted in the same cycle during RUN → no strobe and the map is unchanged; later ticks are ignored; `start` → map 0, count 0, SAFE.
- `rst_n` pulled low mid-GAP, off a clock edge → all outputs are 0 immediately; after release, `start` plus 8 ticks reproduces the first-run map sequence.
- `level`=0 versus `level`=3 over 4096 ticks each, with the same start cycle → obstacle density for level 3 exceeds level 0.
